// File: rtl/bus_addr_decoder_pkg.sv
// Shared types for the on-chip bus address decoder family.
// FSM state encoding, response codes and a select-index width helper.
package bus_dec_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEL  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    RSP_OK      = 2'b00,
    RSP_DECERR  = 2'b01,
    RSP_TIMEOUT = 2'b10
  } rsp_code_e;

  // A single-slave decoder still needs a 1-bit index port.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_addr_decoder_if.sv
// Request/select/response bundle between the bus master, the decoder and the slaves.
// The decoder connects through the slave modport; the master side uses master.
interface bus_addr_decoder_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned NSLV   = 4,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned IDX_W  = bus_dec_pkg::idx_width(NSLV)
);

  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic              req_ready;
  logic [NSLV-1:0]   sel;
  logic [NSLV-1:0]   slv_ack;
  logic              rsp_valid;
  logic [1:0]        rsp_code;
  logic [IDX_W-1:0]  rsp_idx;
  logic [CNT_W-1:0]  err_cnt;

  modport slave (
    input  req_valid, req_addr, slv_ack,
    output req_ready, sel, rsp_valid, rsp_code, rsp_idx, err_cnt
  );

  modport master (
    output req_valid, req_addr, slv_ack,
    input  req_ready, sel, rsp_valid, rsp_code, rsp_idx, err_cnt
  );

endinterface

// File: rtl/bus_addr_decoder_match.sv
// Combinational address-field match: extracts the decode field and produces
// hit, slave index and one-hot select. Bits outside the field are ignored.
module bus_addr_match
  import bus_dec_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned NSLV     = 4,
  parameter int unsigned SEL_LSB  = 16,
  parameter int unsigned SEL_W    = 3,
  parameter int unsigned BASE_IDX = 1,
  parameter int unsigned IDX_W    = idx_width(NSLV)
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              hit,
  output logic [IDX_W-1:0]  idx,
  output logic [NSLV-1:0]   onehot
);

  logic [SEL_W-1:0] field;
  int unsigned      field_val;
  logic             unused_addr;

  assign field       = addr[SEL_LSB +: SEL_W];
  assign unused_addr = ^addr;

  always_comb begin
    field_val = 32'(field);
    hit       = (field_val >= BASE_IDX) && (field_val < BASE_IDX + NSLV);
    idx       = IDX_W'(field_val - BASE_IDX);
    onehot    = hit ? (NSLV'(1) << idx) : '0;
  end

endmodule

// File: rtl/bus_addr_decoder.sv
// Registered address decoder: latches one request, drives a one-hot slave select
// until ack or timeout, then issues a single-cycle response; counts errors.
module bus_addr_decoder
  import bus_dec_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned NSLV     = 4,
  parameter int unsigned SEL_LSB  = 16,
  parameter int unsigned SEL_W    = 3,
  parameter int unsigned BASE_IDX = 1,
  parameter int unsigned TIMEOUT  = 16,
  parameter int unsigned CNT_W    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  bus_addr_decoder_if.slave  bus
);

  localparam int unsigned IDX_W = idx_width(NSLV);
  localparam int unsigned TMR_W = $clog2(TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic             req_ready_q, req_ready_d;
  logic [NSLV-1:0]  sel_q, sel_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [1:0]       rsp_code_q, rsp_code_d;
  logic [IDX_W-1:0] rsp_idx_q, rsp_idx_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             err_inc;

  logic             m_hit;
  logic [IDX_W-1:0] m_idx;
  logic [NSLV-1:0]  m_onehot;

  bus_addr_match #(
    .ADDR_W   (ADDR_W),
    .NSLV     (NSLV),
    .SEL_LSB  (SEL_LSB),
    .SEL_W    (SEL_W),
    .BASE_IDX (BASE_IDX),
    .IDX_W    (IDX_W)
  ) u_match (
    .addr   (bus.req_addr),
    .hit    (m_hit),
    .idx    (m_idx),
    .onehot (m_onehot)
  );

  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    sel_d       = sel_q;
    rsp_valid_d = 1'b0;
    rsp_code_d  = rsp_code_q;
    rsp_idx_d   = rsp_idx_q;
    idx_d       = idx_q;
    timer_d     = timer_q;
    err_inc     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // req_ready_q is still 0 in the first cycle after reset, so no accept there.
        req_ready_d = 1'b1;
        if (bus.req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          if (m_hit) begin
            state_d = ST_SEL;
            sel_d   = m_onehot;
            idx_d   = m_idx;
            timer_d = '0;
          end else begin
            state_d     = ST_RESP;
            sel_d       = '0;
            rsp_valid_d = 1'b1;
            rsp_code_d  = RSP_DECERR;
            rsp_idx_d   = '0;
            err_inc     = 1'b1;
          end
        end
      end

      ST_SEL: begin
        // Masking with the held select ignores acks from other slaves; ack beats timeout.
        if (|(bus.slv_ack & sel_q)) begin
          state_d     = ST_RESP;
          sel_d       = '0;
          rsp_valid_d = 1'b1;
          rsp_code_d  = RSP_OK;
          rsp_idx_d   = idx_q;
        end else if (timer_q == TMR_LAST) begin
          state_d     = ST_RESP;
          sel_d       = '0;
          rsp_valid_d = 1'b1;
          rsp_code_d  = RSP_TIMEOUT;
          rsp_idx_d   = idx_q;
          err_inc     = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      ST_RESP: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
      end

      default: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b0;
        sel_d       = '0;
      end
    endcase

    err_cnt_d = (err_inc && (err_cnt_q != '1)) ? err_cnt_q + 1'b1 : err_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      req_ready_q <= 1'b0;
      sel_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_code_q  <= '0;
      rsp_idx_q   <= '0;
      idx_q       <= '0;
      err_cnt_q   <= '0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      sel_q       <= sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_code_q  <= rsp_code_d;
      rsp_idx_q   <= rsp_idx_d;
      idx_q       <= idx_d;
      err_cnt_q   <= err_cnt_d;
      timer_q     <= timer_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.sel       = sel_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_code  = rsp_code_q;
  assign bus.rsp_idx   = rsp_idx_q;
  assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_bus_addr_decoder.sv
// Directed self-checking bench for bus_addr_decoder with default parameters.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_bus_addr_decoder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  bus_addr_decoder_if #(.ADDR_W(32), .NSLV(4), .CNT_W(8)) dif ();

  bus_addr_decoder #(
    .ADDR_W   (32),
    .NSLV     (4),
    .SEL_LSB  (16),
    .SEL_W    (3),
    .BASE_IDX (1),
    .TIMEOUT  (16),
    .CNT_W    (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dif)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Waits (bounded) for req_ready, presents addr for one accepting edge, returns at negedge.
  task automatic issue(input logic [31:0] addr);
    int unsigned i = 0;
    while (dif.req_ready !== 1'b1 && i < 50) begin
      @(negedge clk);
      i++;
    end
    check("ready_wait", 32'(dif.req_ready), 32'd1);
    dif.req_valid = 1'b1;
    dif.req_addr  = addr;
    @(negedge clk);
    dif.req_valid = 1'b0;
    dif.req_addr  = $urandom;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned dec_f[3];
    int unsigned sat_f[4];
    logic [31:0] a;

    dec_f = '{0, 5, 7};
    sat_f = '{0, 5, 6, 7};
    dif.req_valid = 1'b0;
    dif.req_addr  = '0;
    dif.slv_ack   = '0;

    // Reset
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready",     32'(dif.req_ready), 32'd0);
    check("rst_sel",       32'(dif.sel),       32'd0);
    check("rst_rsp_valid", 32'(dif.rsp_valid), 32'd0);
    check("rst_rsp_code",  32'(dif.rsp_code),  32'd0);
    check("rst_rsp_idx",   32'(dif.rsp_idx),   32'd0);
    check("rst_err_cnt",   32'(dif.err_cnt),   32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 32'(dif.req_ready), 32'd1);

    // Mapped requests, ack two cycles after select
    for (int k = 0; k < 4; k++) begin
      issue(32'(k + 1) << 16);
      check("map_sel",       32'(dif.sel),       32'd1 << k);
      check("map_ready_low", 32'(dif.req_ready), 32'd0);
      @(negedge clk);
      check("map_sel_hold",  32'(dif.sel),       32'd1 << k);
      dif.slv_ack = 4'(1 << k);
      @(negedge clk);
      dif.slv_ack = '0;
      check("map_rsp_valid", 32'(dif.rsp_valid), 32'd1);
      check("map_rsp_code",  32'(dif.rsp_code),  32'd0);
      check("map_rsp_idx",   32'(dif.rsp_idx),   32'(k));
      check("map_sel_clr",   32'(dif.sel),       32'd0);
      @(negedge clk);
      check("map_rsp_1cyc",  32'(dif.rsp_valid), 32'd0);
      check("map_code_hold", 32'(dif.rsp_code),  32'd0);
    end
    check("map_err_cnt", 32'(dif.err_cnt), 32'd0);

    // Unmapped fields
    for (int j = 0; j < 3; j++) begin
      issue(32'(dec_f[j]) << 16);
      check("dec_rsp_valid", 32'(dif.rsp_valid), 32'd1);
      check("dec_rsp_code",  32'(dif.rsp_code),  32'd1);
      check("dec_rsp_idx",   32'(dif.rsp_idx),   32'd0);
      check("dec_sel",       32'(dif.sel),       32'd0);
      @(negedge clk);
      check("dec_rsp_1cyc",  32'(dif.rsp_valid), 32'd0);
    end
    check("dec_err_cnt", 32'(dif.err_cnt), 32'd3);

    // Timeout, with a stray ack from a non-selected slave
    issue(32'h0002_0000);
    for (int i = 0; i < 16; i++) begin
      check("to_sel_held",  32'(dif.sel),       32'd2);
      check("to_no_rsp",    32'(dif.rsp_valid), 32'd0);
      dif.slv_ack = (i == 5) ? 4'b0001 : 4'b0000;
      @(negedge clk);
    end
    dif.slv_ack = '0;
    check("to_rsp_valid", 32'(dif.rsp_valid), 32'd1);
    check("to_rsp_code",  32'(dif.rsp_code),  32'd2);
    check("to_rsp_idx",   32'(dif.rsp_idx),   32'd1);
    check("to_sel_clr",   32'(dif.sel),       32'd0);
    check("to_err_cnt",   32'(dif.err_cnt),   32'd4);

    // Ack coinciding with the timeout edge
    issue(32'h0002_0000);
    for (int i = 0; i < 16; i++) begin
      check("tc_sel_held", 32'(dif.sel), 32'd2);
      dif.slv_ack = (i == 15) ? 4'b0010 : 4'b0000;
      @(negedge clk);
    end
    dif.slv_ack = '0;
    check("tc_rsp_valid", 32'(dif.rsp_valid), 32'd1);
    check("tc_rsp_code",  32'(dif.rsp_code),  32'd0);
    check("tc_rsp_idx",   32'(dif.rsp_idx),   32'd1);
    check("tc_err_cnt",   32'(dif.err_cnt),   32'd4);
    @(negedge clk);

    // Reset mid-transaction
    issue(32'h0003_0000);
    check("mr_sel", 32'(dif.sel), 32'd4);
    rst_n = 1'b0;
    @(negedge clk);
    check("mr_sel_clr",   32'(dif.sel),       32'd0);
    check("mr_no_rsp",    32'(dif.rsp_valid), 32'd0);
    check("mr_err_cnt",   32'(dif.err_cnt),   32'd0);
    check("mr_ready_low", 32'(dif.req_ready), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("mr_no_rsp2",   32'(dif.rsp_valid), 32'd0);
    check("mr_ready",     32'(dif.req_ready), 32'd1);

    // Saturation with random upper address bits
    for (int j = 0; j < 300; j++) begin
      a = $urandom;
      a[18:16] = 3'(sat_f[j % 4]);
      issue(a);
      check("sat_rsp_valid", 32'(dif.rsp_valid), 32'd1);
      check("sat_rsp_code",  32'(dif.rsp_code),  32'd1);
      @(negedge clk);
    end
    check("sat_err_cnt", 32'(dif.err_cnt), 32'd255);

    // Mapped requests with random upper address bits
    for (int k = 0; k < 4; k++) begin
      a = $urandom;
      a[18:16] = 3'(k + 1);
      issue(a);
      check("rnd_sel", 32'(dif.sel), 32'd1 << k);
      dif.slv_ack = 4'(1 << k);
      @(negedge clk);
      dif.slv_ack = '0;
      check("rnd_rsp_code", 32'(dif.rsp_code), 32'd0);
      check("rnd_rsp_idx",  32'(dif.rsp_idx),  32'(k));
      @(negedge clk);
    end
    check("rnd_err_cnt", 32'(dif.err_cnt), 32'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
